button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Collects single-cycle debounced press pulses from N_BTN debouncer instances.
- Holds one pending flag per button and serialises the flags into a single event stream with a valid/ready handshake toward the control FSM.
- Selects among pending buttons with round-robin arbitration.
- Enforces a programmable quiet gap after each delivered event, and flags presses lost because the same button was already pending.

Parameters:
- N_BTN, 4, number of button pulse inputs (2..16).
- ID_W, 2, width of the event id; must equal ceil(log2(N_BTN)).
- GAP_CYCLES, 8, idle cycles inserted after each accepted event (0..255).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_pulse  input  N_BTN  one-cycle press pulses, one bit per debouncer output.
- evt_ready  input  1  consumer can accept the offered event.
- clr_overflow  input  1  synchronous clear of the overflow flag.
- evt_valid  output  1  event offered on evt_id.
- evt_id  output  ID_W  index of the button being offered.
- pending  output  N_BTN  registered pending flags.
- overflow  output  1  sticky lost-press indicator.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
Reset (rst low, asynchronous):
- evt_valid=0, evt_id=0, pending=0, overflow=0, busy=0.
- Round-robin pointer ptr=0, gap counter=0, state=IDLE.
- Reset asserted mid-offer drops the offered event and all pending flags.

Pending capture, every edge:
- pending[i] <= (pending[i] & ~clear[i]) | btn_pulse[i].
- clear[i] is high only on the handshake edge (evt_valid & evt_ready) for i == evt_id.
- A pulse coincident with the clear of the same bit leaves pending[i]=1 (a new event). No overflow in that case.
- overflow sets when btn_pulse[i] & pending[i] & ~clear[i] for any i.
- overflow clears on clr_overflow. If set and clear occur on the same edge, set wins.

State machine:
- IDLE:
  - If pending != 0, choose the first set bit searching ptr, ptr+1, ..., N_BTN-1, 0, ..., ptr-1.
  - Register evt_id=chosen and evt_valid=1, then go to OFFER.
  - Otherwise stay in IDLE.
  - Pulses that arrive in IDLE are seen one edge later through pending.
- OFFER:
  - evt_valid and evt_id stay stable until the handshake. New pulses never change evt_id.
  - On the handshake edge: clear pending[evt_id], set ptr=(evt_id+1) mod N_BTN (N_BTN-1 wraps to 0), evt_valid=0.
  - Then load the counter with GAP_CYCLES and go to GAP, or go straight to IDLE if GAP_CYCLES==0.
- GAP:
  - Decrement the counter each cycle and go to IDLE on the edge where the counter equals 1.
  - Pending capture continues during GAP.

Latency and width rules:
- A pulse high in cycle 0 from IDLE with empty pending gives pending[i]=1 in cycle 1 and evt_valid=1 in cycle 2.
- After a handshake at the end of cycle c, evt_valid is low for exactly GAP_CYCLES+1 cycles when another event is pending.
- Only ids 0..N_BTN-1 are ever produced. For non-power-of-two N_BTN, unused codes never appear.
- evt_ready while evt_valid=0 is ignored.
- busy = (state != IDLE).

Test Plan:
1. Reset, then pulse btn_pulse=4'b0100 in cycle 0 with evt_ready=1 -> evt_valid=1, evt_id=2 in cycle 2; pending=0 after handshake; ptr=3.
2. pending=4'b1111 with ptr=0, evt_ready held 1, GAP_CYCLES=8 -> ids 0,1,2,3 in order; each evt_valid pulse separated by exactly 9 low cycles.
3. With ptr=3 after serving id 2, pulse buttons 0 and 3 together -> id 3 is offered first, then id 0 (wrap-around).
4. evt_ready=0 for 20 cycles while buttons 1 and 3 pulse -> evt_id holds its first value, overflow=0. A second pulse on button 1 -> overflow=1 and stays 1. clr_overflow -> overflow=0.
5. Pulse of button 2 on the exact handshake edge of id 2 -> pending[2] stays 1, overflow=0, id 2 is re-offered after the gap.
6. Assert rst low while evt_valid=1 with pending=4'b1010 -> all outputs 0 immediately (asynchronous). After release with no pulses, evt_valid stays 0 and ptr=0.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Button event arbiter.
// Latches one-cycle press pulses from the debouncers into per-button pending
// flags and serialises them, round-robin, into a single valid/ready event
// stream. A programmable quiet gap follows every delivered event, and a sticky
// overflow flag records presses lost because that button was already pending.
module button_event_arbiter #(
   parameter int N_BTN      = 4,
   parameter int ID_W       = 2,
   parameter int GAP_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_BTN-1:0]  btn_pulse,
   input  logic              evt_ready,
   input  logic              clr_overflow,
   output logic              evt_valid,
   output logic [ID_W-1:0]   evt_id,
   output logic [N_BTN-1:0]  pending,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_OFFER = 2'b01,
      ST_GAP   = 2'b10
   } state_t;

   localparam logic [7:0]      GAP_LOAD = 8'(GAP_CYCLES);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_BTN - 1);

   state_t              state_r;
   logic [ID_W-1:0]     ptr_r;
   logic [7:0]          gap_cnt_r;

   logic                handshake_s;
   logic [N_BTN-1:0]    clear_s;
   logic [N_BTN-1:0]    lost_s;
   logic                pick_found_s;
   logic [ID_W-1:0]     pick_id_s;

   // Round-robin pick: rotate the request vector so the search starts at
   // base, take the lowest set bit, then map it back to an absolute index.
   // The result is always below N_BTN, so unused id codes never appear.
   function automatic logic [ID_W:0] rr_pick(input logic [N_BTN-1:0] req,
                                             input logic [ID_W-1:0]  base);
      logic [N_BTN-1:0] rot;
      logic             found;
      logic [ID_W-1:0]  id;
      int               sum;
      rot   = (req >> base) | (req << (N_BTN - int'(base)));
      found = 1'b0;
      id    = '0;
      for (int j = 0; j < N_BTN; j++) begin
         if (!found && rot[j]) begin
            sum   = int'(base) + j;
            sum   = (sum >= N_BTN) ? (sum - N_BTN) : sum;
            found = 1'b1;
            id    = ID_W'(sum);
         end else begin
            found = found;
         end
      end
      return {found, id};
   endfunction

   // Handshake decode and the one-hot clear of the offered button's flag.
   always_comb begin
      handshake_s = evt_valid & evt_ready;
      clear_s     = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (handshake_s && (evt_id == ID_W'(i))) begin
            clear_s[i] = 1'b1;
         end else begin
            clear_s[i] = 1'b0;
         end
      end
      lost_s = btn_pulse & pending & ~clear_s;
   end

   // Arbitration among the registered pending flags starting at ptr_r.
   always_comb begin
      {pick_found_s, pick_id_s} = rr_pick(pending, ptr_r);
   end

   // Pending flags: a pulse on the clear edge re-arms the bit as a new event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clear_s) | btn_pulse;
      end
   end

   // Sticky overflow: a lost press beats a simultaneous clear request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (|lost_s) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end else begin
         overflow <= overflow;
      end
   end

   // Offer/gap state machine with registered event, pointer and busy outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         evt_valid <= 1'b0;
         evt_id    <= '0;
         ptr_r     <= '0;
         gap_cnt_r <= 8'd0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_found_s) begin
                  evt_id    <= pick_id_s;
                  evt_valid <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= ST_OFFER;
               end else begin
                  evt_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            ST_OFFER: begin
               if (handshake_s) begin
                  evt_valid <= 1'b0;
                  ptr_r     <= (evt_id == LAST_ID) ? '0 : (evt_id + ID_W'(1));
                  if (GAP_CYCLES == 0) begin
                     busy    <= 1'b0;
                     state_r <= ST_IDLE;
                  end else begin
                     gap_cnt_r <= GAP_LOAD;
                     busy      <= 1'b1;
                     state_r   <= ST_GAP;
                  end
               end else begin
                  evt_valid <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= ST_OFFER;
               end
            end
            ST_GAP: begin
               // Counter at 1 (or a stray 0) ends the gap, so it can never stall.
               if (gap_cnt_r <= 8'd1) begin
                  gap_cnt_r <= 8'd0;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r - 8'd1;
                  busy      <= 1'b1;
                  state_r   <= ST_GAP;
               end
            end
            default: begin
               evt_valid <= 1'b0;
               gap_cnt_r <= 8'd0;
               busy      <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Testbench for button_event_arbiter: directed stimulus with a queue of
// expected event ids, compared whenever a handshake is observed.
module tb_button_event_arbiter;

   localparam int N_BTN      = 4;
   localparam int ID_W       = 2;
   localparam int GAP_CYCLES = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N_BTN-1:0] btn_pulse = '0;
   logic             evt_ready = 1'b0;
   logic             clr_overflow = 1'b0;
   logic             evt_valid;
   logic [ID_W-1:0]  evt_id;
   logic [N_BTN-1:0] pending;
   logic             overflow;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int sb[$];
   logic gap_chk_en = 1'b0;
   int low_run = 0;
   logic run_seen = 1'b0;

   button_event_arbiter #(.N_BTN(N_BTN), .ID_W(ID_W), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .evt_ready(evt_ready),
      .clr_overflow(clr_overflow), .evt_valid(evt_valid), .evt_id(evt_id),
      .pending(pending), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Scoreboard and gap-length monitor, sampled on the falling edge.
   always @(negedge clk) begin
      int e;
      if (rst && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_id", int'(evt_id), e);
         end
      end
      if (!gap_chk_en) begin
         run_seen = 1'b0;
         low_run  = 0;
      end else if (evt_valid) begin
         if (run_seen) chk("gap_len", low_run, GAP_CYCLES + 1);
         run_seen = 1'b1;
         low_run  = 0;
      end else begin
         low_run++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [N_BTN-1:0] m);
      btn_pulse = m;
      step();
      btn_pulse = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || pending != '0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", (n < budget) ? 1 : 0, 1);
      step();
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!evt_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("valid_seen", int'(evt_valid), 1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      // Reset state
      @(negedge clk);
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_id", int'(evt_id), 0);
      chk("rst_pend", int'(pending), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
      do_reset();

      // 1: single press latency and clear on handshake
      evt_ready = 1'b1;
      sb.push_back(2);
      pulse(4'b0100);
      @(negedge clk);
      chk("t1_pend_c1", int'(pending), 4);
      chk("t1_valid_c1", int'(evt_valid), 0);
      step();
      @(negedge clk);
      chk("t1_valid_c2", int'(evt_valid), 1);
      chk("t1_id_c2", int'(evt_id), 2);
      chk("t1_busy_c2", int'(busy), 1);
      step();
      @(negedge clk);
      chk("t1_pend_c3", int'(pending), 0);
      chk("t1_valid_c3", int'(evt_valid), 0);
      chk("t1_busy_c3", int'(busy), 1);
      drain(60);

      // 2: all four pending from ptr=0, gap length between offers
      do_reset();
      gap_chk_en = 1'b1;
      evt_ready = 1'b1;
      for (int i = 0; i < N_BTN; i++) sb.push_back(i);
      pulse(4'b1111);
      drain(200);
      gap_chk_en = 1'b0;

      // 3: wrap-around after serving id 2
      sb.push_back(2);
      pulse(4'b0100);
      drain(60);
      sb.push_back(3);
      sb.push_back(0);
      pulse(4'b1001);
      drain(100);

      // 4: stall, overflow set, sticky, set-wins, clear
      evt_ready = 1'b0;
      pulse(4'b1010);
      wait_valid(10);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!evt_valid || evt_id != 2'd1) bad++;
      end
      chk("t4_hold", bad, 0);
      chk("t4_ovf0", int'(overflow), 0);
      step();
      pulse(4'b0010);
      @(negedge clk);
      chk("t4_ovf_set", int'(overflow), 1);
      repeat (3) step();
      @(negedge clk);
      chk("t4_ovf_sticky", int'(overflow), 1);
      step();
      btn_pulse = 4'b0010;
      clr_overflow = 1'b1;
      step();
      btn_pulse = '0;
      clr_overflow = 1'b0;
      @(negedge clk);
      chk("t4_set_wins", int'(overflow), 1);
      step();
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      @(negedge clk);
      chk("t4_ovf_clr", int'(overflow), 0);
      step();
      sb.push_back(1);
      sb.push_back(3);
      evt_ready = 1'b1;
      drain(100);

      // 5: pulse coincident with its own handshake re-arms the bit
      evt_ready = 1'b0;
      pulse(4'b0100);
      wait_valid(10);
      sb.push_back(2);
      sb.push_back(2);
      evt_ready = 1'b1;
      btn_pulse = 4'b0100;
      step();
      btn_pulse = '0;
      @(negedge clk);
      chk("t5_pend", int'(pending), 4);
      chk("t5_ovf", int'(overflow), 0);
      chk("t5_valid", int'(evt_valid), 0);
      drain(60);

      // 6: asynchronous reset mid-offer, then ptr restarts at 0
      evt_ready = 1'b0;
      pulse(4'b1010);
      wait_valid(10);
      chk("t6_id", int'(evt_id), 3);
      chk("t6_pend", int'(pending), 10);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_valid", int'(evt_valid), 0);
      chk("t6_rst_id", int'(evt_id), 0);
      chk("t6_rst_pend", int'(pending), 0);
      chk("t6_rst_busy", int'(busy), 0);
      step();
      step();
      rst = 1'b1;
      evt_ready = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (evt_valid) bad++;
      end
      chk("t6_quiet", bad, 0);
      step();
      sb.push_back(1);
      sb.push_back(3);
      pulse(4'b1010);
      drain(100);

      chk("sb_left", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
